flappy_pipe_gen: RTL and testbench

Pipe-field generator for the Flappy game, sitting directly upstream of the VGA output stage. It owns the four scrolling pipes: their horizontal positions, the gap heights (pseudo-random at respawn) and the "next pipe" edge X_Edge. Positions advance once per video frame under a small run/halt state machine. Its registered outputs feed the renderer's pipe rectangles and the collision/score logic.

---
 rtl/flappy_pipe_gen_pkg.sv | 30 +++
 rtl/flappy_pipe_gen_if.sv | 26 ++
 rtl/flappy_pipe_gen_lfsr.sv | 23 ++
 rtl/flappy_pipe_gen.sv | 126 ++++++++++++
 tb/tb_flappy_pipe_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/flappy_pipe_gen_pkg.sv
// Shared constants, state type and helpers for the Flappy pipe-field blocks.
package flappy_pipe_gen_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned NUM_PIPES = 4;
    localparam int unsigned XW        = 10;

    localparam int unsigned DEF_SPEED   = 2;
    localparam int unsigned DEF_SPACING = 170;
    localparam int unsigned DEF_WIDTH   = 40;
    localparam int unsigned DEF_GAP     = 120;
    localparam int unsigned DEF_GAP_MIN = 40;
    localparam int unsigned DEF_BIRD_X  = 80;
    localparam int unsigned GAP_HOME    = 180;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef logic [XW-1:0] coord_t;

    // Right edge of pipe idx on reset / restart.
    function automatic coord_t home_x(input int unsigned idx, input int unsigned spacing);
        return coord_t'((idx + 1) * spacing - 1);
    endfunction

endpackage

// File: rtl/flappy_pipe_gen_if.sv
// Control pulses in, pipe geometry out; master is the pipe generator side.
interface flappy_pipe_gen_if;
    import flappy_pipe_gen_pkg::*;

    logic                       frame_tick;
    logic                       start;
    logic                       crash;
    logic [NUM_PIPES*XW-1:0]    PipeRight;
    logic [NUM_PIPES*XW-1:0]    PipeLeft;
    logic [NUM_PIPES*XW-1:0]    PipeGapTop;
    logic [NUM_PIPES*XW-1:0]    PipeGapBot;
    logic [XW-1:0]              X_Edge;
    logic                       running;
    logic                       pipe_passed;

    modport master (
        input  frame_tick, start, crash,
        output PipeRight, PipeLeft, PipeGapTop, PipeGapBot, X_Edge, running, pipe_passed
    );

    modport slave (
        output frame_tick, start, crash,
        input  PipeRight, PipeLeft, PipeGapTop, PipeGapBot, X_Edge, running, pipe_passed
    );

endinterface

// File: rtl/flappy_pipe_gen_lfsr.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1), seeded with 1 on reset; low OUT_W bits exposed.
module flappy_lfsr #(
    parameter int unsigned OUT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [OUT_W-1:0] value
);

    logic [9:0] q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 10'h001;
        end else if (enable) begin
            q <= {q[8:0], q[9] ^ q[6]};
        end
    end

    assign value = q[OUT_W-1:0];

endmodule

// File: rtl/flappy_pipe_gen.sv
// Four scrolling pipes with random gap heights, advanced once per frame under an IDLE/RUN/HALT FSM.
module flappy_pipe_gen
    import flappy_pipe_gen_pkg::*;
#(
    parameter int unsigned SPEED   = DEF_SPEED,
    parameter int unsigned SPACING = DEF_SPACING,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned GAP     = DEF_GAP,
    parameter int unsigned GAP_MIN = DEF_GAP_MIN,
    parameter int unsigned BIRD_X  = DEF_BIRD_X
) (
    input  logic               ClkPort,
    input  logic               reset,
    flappy_pipe_gen_if.master  bus
);

    localparam int unsigned PERIOD = NUM_PIPES * SPACING;
    localparam coord_t      BIRD   = coord_t'(BIRD_X);

    state_t                 state;
    logic                   running_q;
    logic                   passed_q;
    logic [7:0]             rand_byte;
    logic                   advance;
    logic                   reinit;
    logic [NUM_PIPES-1:0]   crossed;
    coord_t                 x_q      [NUM_PIPES];
    coord_t                 gap_q    [NUM_PIPES];
    coord_t                 left_q   [NUM_PIPES];
    coord_t                 bot_q    [NUM_PIPES];
    coord_t                 x_nxt    [NUM_PIPES];
    coord_t                 gap_nxt  [NUM_PIPES];
    coord_t                 edge_q;
    coord_t                 edge_nxt;

    flappy_lfsr #(.OUT_W(8)) u_lfsr (
        .clk    (ClkPort),
        .reset  (reset),
        .enable (1'b1),
        .value  (rand_byte)
    );

    // Reset folds into the field reinit path so every registered output takes its home value.
    assign advance = reset && (state == RUN) && bus.frame_tick && !bus.crash;
    assign reinit  = !reset || ((state == HALT) && bus.start);

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        coord_t moved;
        coord_t x_n;
        coord_t gap_n;
        logic   wrap;

        always_comb begin
            wrap  = x_q[i] < coord_t'(SPEED);
            moved = wrap ? x_q[i] + coord_t'(PERIOD - SPEED) : x_q[i] - coord_t'(SPEED);
            x_n   = x_q[i];
            gap_n = gap_q[i];
            if (reinit) begin
                x_n   = home_x(i, SPACING);
                gap_n = coord_t'(GAP_HOME);
            end else if (advance) begin
                x_n = moved;
                if (wrap) begin
                    gap_n = coord_t'(GAP_MIN) + coord_t'(rand_byte);
                end
            end
        end

        assign x_nxt[i]   = x_n;
        assign gap_nxt[i] = gap_n;
        assign crossed[i] = advance && !wrap && (x_q[i] >= BIRD) && (moved < BIRD);

        assign bus.PipeRight [XW*i +: XW] = x_q[i];
        assign bus.PipeLeft  [XW*i +: XW] = left_q[i];
        assign bus.PipeGapTop[XW*i +: XW] = gap_q[i];
        assign bus.PipeGapBot[XW*i +: XW] = bot_q[i];
    end

    always_comb begin
        edge_nxt = '1;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            if ((x_nxt[i] >= BIRD) && (x_nxt[i] < edge_nxt)) begin
                edge_nxt = x_nxt[i];
            end
        end
    end

    always_ff @(posedge ClkPort) begin
        if (!reset) begin
            state     <= IDLE;
            running_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    state     <= RUN;
                    running_q <= 1'b1;
                end
                RUN: if (bus.crash) begin
                    state     <= HALT;
                    running_q <= 1'b0;
                end
                HALT: if (bus.start) begin
                    state     <= RUN;
                    running_q <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
        passed_q <= |crossed;
        edge_q   <= edge_nxt;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            x_q[i]    <= x_nxt[i];
            gap_q[i]  <= gap_nxt[i];
            left_q[i] <= (x_nxt[i] >= coord_t'(WIDTH)) ? x_nxt[i] - coord_t'(WIDTH) : '0;
            bot_q[i]  <= gap_nxt[i] + coord_t'(GAP);
        end
    end

    assign bus.X_Edge      = edge_q;
    assign bus.running     = running_q;
    assign bus.pipe_passed = passed_q;

endmodule

// File: tb/tb_flappy_pipe_gen.sv
// Randomized directed bench for flappy_pipe_gen against a closed-form pipe-position model.
module tb_flappy_pipe_gen;

    localparam int SPEED   = 2;
    localparam int SPACING = 170;
    localparam int PERIOD  = 4 * SPACING;
    localparam int WIDTH   = 40;
    localparam int GAP     = 120;
    localparam int GAP_MIN = 40;
    localparam int BIRD_X  = 80;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flappy_pipe_gen_if bus();

    flappy_pipe_gen #(
        .SPEED   (SPEED),
        .SPACING (SPACING),
        .WIDTH   (WIDTH),
        .GAP     (GAP),
        .GAP_MIN (GAP_MIN),
        .BIRD_X  (BIRD_X)
    ) dut (
        .ClkPort (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: positions are a pure function of ticks since (re)start; gaps and LFSR tracked explicitly.
    int         m_k;
    bit         m_play;
    bit         m_halt;
    int         m_gap [4];
    logic [9:0] m_lfsr;
    bit         m_passed;

    function automatic int pos(input int i, input int k);
        int v;
        v = (i + 1) * SPACING - 1 - SPEED * (k % (PERIOD / SPEED));
        if (v < 0) v += PERIOD;
        return v;
    endfunction

    task automatic model_clock(input bit r, input bit t, input bit s, input bit c);
        logic [9:0] old_lfsr;
        int o, n;
        old_lfsr = m_lfsr;
        m_lfsr   = r ? {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]} : 10'h001;
        m_passed = 1'b0;
        if (!r) begin
            m_play = 0; m_halt = 0; m_k = 0;
            for (int i = 0; i < 4; i++) m_gap[i] = 180;
        end else if (m_play) begin
            if (c) begin
                m_play = 0; m_halt = 1;
            end else if (t) begin
                for (int i = 0; i < 4; i++) begin
                    o = pos(i, m_k);
                    n = pos(i, m_k + 1);
                    if (o < SPEED) m_gap[i] = GAP_MIN + int'(old_lfsr[7:0]);
                    else if (o >= BIRD_X && n < BIRD_X) m_passed = 1'b1;
                end
                m_k++;
            end
        end else if (s) begin
            if (m_halt) begin
                m_k = 0;
                for (int i = 0; i < 4; i++) m_gap[i] = 180;
            end
            m_play = 1; m_halt = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int x, best;
        best = 1023;
        for (int i = 0; i < 4; i++) begin
            x = pos(i, m_k);
            if (x >= BIRD_X && x < best) best = x;
            check($sformatf("right%0d", i), 32'(bus.PipeRight[10*i +: 10]), 32'(x));
            check($sformatf("left%0d", i), 32'(bus.PipeLeft[10*i +: 10]), 32'((x >= WIDTH) ? x - WIDTH : 0));
            check($sformatf("gaptop%0d", i), 32'(bus.PipeGapTop[10*i +: 10]), 32'(m_gap[i]));
            check($sformatf("gapbot%0d", i), 32'(bus.PipeGapBot[10*i +: 10]), 32'(m_gap[i] + GAP));
        end
        check("x_edge", 32'(bus.X_Edge), 32'(best));
        check("running", 32'(bus.running), 32'(m_play));
        check("pipe_passed", 32'(bus.pipe_passed), 32'(m_passed));
    endtask

    task automatic cyc(input bit r, input bit t, input bit s, input bit c);
        rst_n          = r;
        bus.frame_tick = t;
        bus.start      = s;
        bus.crash      = c;
        @(posedge clk);
        model_clock(r, t, s, c);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start = 1'b0;
        bus.crash = 1'b0;
        m_lfsr = 10'h001;

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("init_right3", 32'(bus.PipeRight[39:30]), 32'd679);
        check("init_xedge", 32'(bus.X_Edge), 32'd169);

        // IDLE: ticks and crashes have no effect
        repeat ($urandom_range(3, 10)) cyc(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));

        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        check("first_tick_x0", 32'(bus.PipeRight[9:0]), 32'd167);
        check("first_tick_x3", 32'(bus.PipeRight[39:30]), 32'd677);

        cyc(1, 1, 1, 1);
        check("crash_running", 32'(bus.running), 32'd0);
        check("crash_frozen_x0", 32'(bus.PipeRight[9:0]), 32'd167);

        repeat ($urandom_range(2, 6)) cyc(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
        cyc(1, 0, 1, 0);
        check("restart_x0", 32'(bus.PipeRight[9:0]), 32'd169);
        check("restart_running", 32'(bus.running), 32'd1);

        // Long run with random tick spacing; stray starts in RUN must be ignored
        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 3)) cyc(1, 0, 1'($urandom_range(0, 15) == 0), 0);
            cyc(1, 1, 0, 0);
            if (n == 44) check("pass_pulse", 32'(bus.pipe_passed), 32'd1);
            if (n == 84) check("wrap_x0", 32'(bus.PipeRight[9:0]), 32'd679);
        end

        // Reset mid-run during a tick
        cyc(0, 1, 0, 0);
        check("midreset_running", 32'(bus.running), 32'd0);
        check("midreset_x0", 32'(bus.PipeRight[9:0]), 32'd169);
        cyc(1, 1, 0, 0);
        check("idle_after_reset_x0", 32'(bus.PipeRight[9:0]), 32'd169);

        // Free-running random control
        cyc(1, 0, 1, 0);
        repeat (400) cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                         1'($urandom_range(0, 39) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
